multdiv_ctrl: RTL and testbench

Iterative signed 32-bit multiply/divide sequencer for the processor's execute stage. It sequences a 32-bit add/subtract datapath (subtract formed as A + ~B + 1) through shift-add multiplication or restoring division on operand magnitudes, then applies sign correction. The pipeline stalls on a start pulse until the single-cycle ready pulse.

---
 rtl/multdiv_pkg.sv | 21 ++
 rtl/multdiv_ctrl_if.sv | 23 ++
 rtl/multdiv_ctrl_twos_negate.sv | 16 +
 rtl/multdiv_ctrl.sv | 152 +++++++++++++++
 tb/tb_multdiv_ctrl.sv | 129 ++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package multdiv_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        SIGN,
        DONE
    } stateT;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } opT;

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Operand/control/result bundle between the execute stage and the sequencer.
interface multdiv_ctrl_if;
    import multdiv_pkg::*;

    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );

endinterface

// File: rtl/multdiv_ctrl_twos_negate.sv
// Two's-complement negate: ~x + carryIn, carry-out chains words for wider values.
module twos_negate
    import multdiv_pkg::*;
(
    input  logic [WIDTH-1:0] valueIn,
    input  logic             carryIn,
    output logic [WIDTH-1:0] valueOut,
    output logic             carryOut
);

    // Invert and add the incoming carry (1 for a standalone negate).
    always_comb begin
        {carryOut, valueOut} = {1'b0, ~valueIn} + {{WIDTH{1'b0}}, carryIn};
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// Iterative signed 32-bit multiply/divide sequencer: shift-add multiply and
// restoring divide on magnitudes, followed by a sign-correction step.
module multdiv_ctrl
    import multdiv_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    multdiv_ctrl_if.slave bus
);

    stateT            state, nextState;
    opT               op;
    logic [CNT_W-1:0] count;
    logic             resSign;
    logic [WIDTH-1:0] magA, magB;
    logic [WIDTH-1:0] accHi, accLo;
    logic             excStage;

    logic             start;
    logic             doIter, doSign, doFinish;
    logic [WIDTH-1:0] negA, negB, aMag, bMag;
    logic             bZero, unusedCarryA;
    logic [WIDTH-1:0] addA, addB, addSum;
    logic             addCin, addCout, divNonNeg;
    logic [WIDTH-1:0] negLo, negHi, resLo, resHi;
    logic             negLoCarry, unusedCarryHi;
    logic             multExc, divExc;

    assign start = bus.ctrl_MULT | bus.ctrl_DIV;

    // Operand magnitudes; the B negate carries out only when B is zero.
    twos_negate uNegA (.valueIn(bus.data_operandA), .carryIn(1'b1), .valueOut(negA), .carryOut(unusedCarryA));
    twos_negate uNegB (.valueIn(bus.data_operandB), .carryIn(1'b1), .valueOut(negB), .carryOut(bZero));

    assign aMag = bus.data_operandA[WIDTH-1] ? negA : bus.data_operandA;
    assign bMag = bus.data_operandB[WIDTH-1] ? negB : bus.data_operandB;

    // 64-bit sign correction: low word negate carries into the high word.
    twos_negate uNegLo (.valueIn(accLo), .carryIn(1'b1),       .valueOut(negLo), .carryOut(negLoCarry));
    twos_negate uNegHi (.valueIn(accHi), .carryIn(negLoCarry), .valueOut(negHi), .carryOut(unusedCarryHi));

    assign resLo = resSign ? negLo : accLo;
    assign resHi = resSign ? negHi : accHi;

    // Product fits in 32 bits only when bits [63:31] are all equal.
    assign multExc = ~((&{resHi, resLo[WIDTH-1]}) | ~(|{resHi, resLo[WIDTH-1]}));
    // A quotient magnitude of 2^31 is representable only as a negative result.
    assign divExc  = accLo[WIDTH-1] & ~resSign;

    // Shared 32-bit adder: accumulate for multiply, trial subtract for divide.
    always_comb begin
        if (op == OP_DIV) begin
            addA   = {accHi[WIDTH-2:0], accLo[WIDTH-1]};
            addB   = ~magB;
            addCin = 1'b1;
        end else begin
            addA   = accHi;
            addB   = accLo[0] ? magA : '0;
            addCin = 1'b0;
        end
        {addCout, addSum} = {1'b0, addA} + {1'b0, addB} + {{WIDTH{1'b0}}, addCin};
    end

    // The 33-bit shifted remainder is non-negative after subtraction if its top bit or the carry is set.
    assign divNonNeg = accHi[WIDTH-1] | addCout;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nextState;
    end

    // Next-state logic; a start pulse in any state restarts the sequence.
    always_comb begin
        nextState = state;
        if (start) begin
            if (bus.ctrl_MULT) nextState = MULT;
            else if (bZero)    nextState = DONE;
            else               nextState = DIV;
        end else begin
            case (state)
                IDLE:      nextState = IDLE;
                MULT, DIV: if (count == CNT_W'(ITER - 1)) nextState = SIGN;
                SIGN:      nextState = DONE;
                DONE:      nextState = IDLE;
                default:   nextState = IDLE;
            endcase
        end
    end

    // State decode into datapath step controls.
    always_comb begin
        doIter   = 1'b0;
        doSign   = 1'b0;
        doFinish = 1'b0;
        case (state)
            MULT, DIV: doIter   = 1'b1;
            SIGN:      doSign   = 1'b1;
            DONE:      doFinish = 1'b1;
            default:   ;
        endcase
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op                 <= OP_MULT;
            count              <= '0;
            resSign            <= 1'b0;
            magA               <= '0;
            magB               <= '0;
            accHi              <= '0;
            accLo              <= '0;
            excStage           <= 1'b0;
            bus.data_result    <= '0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
        end else begin
            bus.data_resultRDY <= doFinish & ~start;
            if (start) begin
                op       <= bus.ctrl_MULT ? OP_MULT : OP_DIV;
                resSign  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                magA     <= aMag;
                magB     <= bMag;
                count    <= '0;
                accHi    <= '0;
                // Divide by zero jumps straight to DONE with a zero result staged.
                if (bus.ctrl_MULT)  accLo <= bMag;
                else if (bZero)     accLo <= '0;
                else                accLo <= aMag;
                excStage <= ~bus.ctrl_MULT & bZero;
            end else if (doIter) begin
                count <= count + 1'b1;
                if (op == OP_MULT) begin
                    accHi <= {addCout, addSum[WIDTH-1:1]};
                    accLo <= {addSum[0], accLo[WIDTH-1:1]};
                end else begin
                    accHi <= divNonNeg ? addSum : addA;
                    accLo <= {accLo[WIDTH-2:0], divNonNeg};
                end
            end else if (doSign) begin
                accHi    <= resHi;
                accLo    <= resLo;
                excStage <= (op == OP_MULT) ? multExc : divExc;
            end else if (doFinish) begin
                bus.data_result    <= accLo;
                bus.data_exception <= excStage;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: latency, results, exceptions, abort and reset.
module tb_multdiv_ctrl;

    logic clock = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    int   lat;
    logic sawRdy;

    multdiv_ctrl_if bus ();

    multdiv_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Present a start pulse for one edge, then scramble the operands.
    task automatic startOp(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'hDEAD_BEEF;
        bus.data_operandB = 32'h1234_5678;
    endtask

    // Count cycles after the start edge until ready; gives up at 100.
    task automatic waitReady(output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (bus.data_resultRDY !== 1'b1 && cycles < 100);
    endtask

    task automatic runOp(input string tag, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b,
                         input int expLat, input logic [31:0] expRes, input logic expExc);
        int l;
        startOp(m, d, a, b);
        waitReady(l);
        check32({tag, " latency"}, 32'(l), 32'(expLat));
        check32({tag, " result"}, bus.data_result, expRes);
        check32({tag, " exception"}, {31'b0, bus.data_exception}, {31'b0, expExc});
        @(negedge clock);
        check32({tag, " ready pulse width"}, {31'b0, bus.data_resultRDY}, 32'd0);
        check32({tag, " result held"}, bus.data_result, expRes);
    endtask

    initial begin
        reset_n           = 1'b0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        #12;
        check32("reset result", bus.data_result, 32'd0);
        check32("reset exception", {31'b0, bus.data_exception}, 32'd0);
        check32("reset ready", {31'b0, bus.data_resultRDY}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        runOp("mult 7*-6", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 34, 32'hFFFF_FFD6, 1'b0);
        runOp("mult 2^16*2^16", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 34, 32'h0000_0000, 1'b1);
        runOp("mult min*1", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 34, 32'h8000_0000, 1'b0);
        runOp("mult -3*-5", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 34, 32'd15, 1'b0);
        runOp("div -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 1'b0);
        runOp("div 7/-2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, 1'b0);
        runOp("div min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 1'b1);

        // Divide by zero: previous result held until the DONE edge right after start.
        startOp(1'b0, 1'b1, 32'd55, 32'd0);
        check32("div0 prior result held", bus.data_result, 32'h8000_0000);
        check32("div0 no early ready", {31'b0, bus.data_resultRDY}, 32'd0);
        waitReady(lat);
        check32("div0 latency", 32'(lat), 32'd1);
        check32("div0 result", bus.data_result, 32'd0);
        check32("div0 exception", {31'b0, bus.data_exception}, 32'd1);
        @(negedge clock);
        check32("div0 ready pulse width", {31'b0, bus.data_resultRDY}, 32'd0);

        // Abort: a DIV ten cycles into a MULT replaces it; only one ready follows.
        startOp(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (8) @(negedge clock);
        runOp("abort div 100/7", 1'b0, 1'b1, 32'd100, 32'd7, 34, 32'd14, 1'b0);

        runOp("both high mult wins", 1'b1, 1'b1, 32'd6, 32'd3, 34, 32'd18, 1'b0);

        // Asynchronous reset in the middle of a divide.
        startOp(1'b0, 1'b1, 32'd1000, 32'd3);
        repeat (19) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check32("midreset result", bus.data_result, 32'd0);
        check32("midreset exception", {31'b0, bus.data_exception}, 32'd0);
        check32("midreset ready", {31'b0, bus.data_resultRDY}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        sawRdy  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) sawRdy = 1'b1;
        end
        check32("midreset no ready", {31'b0, sawRdy}, 32'd0);
        runOp("mult 5*5 after reset", 1'b1, 1'b0, 32'd5, 32'd5, 34, 32'd25, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
